descramble_mw: RTL and testbench



---
 rtl/descramble_pkg.sv | 18 +
 rtl/descramble_mw_core.sv | 18 +
 rtl/descramble_mw.sv | 96 +++++++++
 tb/tb_descramble_mw.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/descramble_pkg.sv
// Shared definitions for the multiplicative descrambler family.
//   - default word width and tap delays
//   - lock state machine encoding
//   - nfill(): number of accepted words needed to load the history from line data
package descramble_pkg;

  localparam int DEF_W    = 10;
  localparam int DEF_TAP1 = 4;
  localparam int DEF_TAP2 = 23;

  typedef enum logic {FLUSH = 1'b0, LOCKED = 1'b1} state_e;

  // ceil(tap2 / w): words until every history bit came off the line
  function automatic int nfill(input int tap2, input int w);
    return (tap2 + w - 1) / w;
  endfunction

endpackage

// File: rtl/descramble_mw_core.sv
// Combinational tap network of the multiplicative descrambler.
// Ports:
//   c  in  TAP2+W  {history, word}; higher index is earlier in time
//   d  out W       descrambled word, d[i] = c[i] ^ c[i+TAP1] ^ c[i+TAP2]
module descramble_mw_core import descramble_pkg::*; #(
  parameter int W    = DEF_W,
  parameter int TAP1 = DEF_TAP1,
  parameter int TAP2 = DEF_TAP2
) (
  input  logic [TAP2+W-1:0] c,
  output logic [W-1:0]      d
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign d[i] = c[i] ^ c[i+TAP1] ^ c[i+TAP2];
  end

endmodule

// File: rtl/descramble_mw.sv
// Parametrised self-synchronising descrambler with valid handshake,
// registered output, flush/lock state machine, runtime flush and bypass.
// Ports:
//   rclk, rst_n         receive word clock, async active-low reset
//   in_valid, in_data   scrambled word (bit W-1 earliest in time)
//   flush               pulse: reload history with SEED, re-enter FLUSH
//   bypass              pass the accepted word through unmodified
//   out_valid, out_data descrambled word, one cycle after acceptance
//   locked              history fully loaded from line data
//   word_cnt            (DESCRAMBLE_MW_WORDCNT_EN only) saturating count of
//                       out_valid cycles with locked=1, cleared by flush
module descramble_mw import descramble_pkg::*; #(
  parameter int            W             = DEF_W,
  parameter int            TAP1          = DEF_TAP1,
  parameter int            TAP2          = DEF_TAP2,
  parameter logic [TAP2-1:0] SEED        = TAP2'(1),
  parameter bit            DROP_UNLOCKED = 1'b0
) (
  input  logic         rclk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         flush,
  input  logic         bypass,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         locked
`ifdef DESCRAMBLE_MW_WORDCNT_EN
  ,
  output logic [31:0]  word_cnt
`endif
);

  localparam int HIST  = TAP2;
  localparam int NFILL = nfill(TAP2, W);
  localparam int CW    = $clog2(NFILL + 1);
  localparam logic [CW-1:0] LAST = CW'(NFILL - 1);
  localparam logic [CW-1:0] FULL = CW'(NFILL);

  state_e            state;
  logic [HIST-1:0]   hist;
  logic [CW-1:0]     fill_cnt;
  logic [HIST+W-1:0] c;
  logic [W-1:0]      d;
  logic              lock_nxt;

  assign c = {hist, in_data};

  // the word being accepted now is the last one of the fill, or we are already locked
  assign lock_nxt = (state == LOCKED) || (fill_cnt == LAST);

  descramble_mw_core #(.W(W), .TAP1(TAP1), .TAP2(TAP2)) u_core (
    .c(c),
    .d(d)
  );

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FLUSH;
      hist      <= SEED;
      fill_cnt  <= '0;
      locked    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      // a word arriving with flush is dropped and never reaches the history
      state     <= FLUSH;
      hist      <= SEED;
      fill_cnt  <= '0;
      locked    <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      // scrambled bits always feed the history, bypass only affects the output
      hist      <= c[HIST-1:0];
      out_data  <= bypass ? in_data : d;
      out_valid <= lock_nxt | ~DROP_UNLOCKED;
      if (fill_cnt != FULL) fill_cnt <= fill_cnt + CW'(1);
      if (lock_nxt) begin
        state  <= LOCKED;
        locked <= 1'b1;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef DESCRAMBLE_MW_WORDCNT_EN
  // counts the output slots that carry locked=1
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n)                                        word_cnt <= '0;
    else if (flush)                                    word_cnt <= '0;
    else if (in_valid && lock_nxt && word_cnt != '1)   word_cnt <= word_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_descramble_mw.sv
// Bench for descramble_mw: serial bit-stream scrambler/descrambler model,
// randomized data, default DUT plus a DROP_UNLOCKED=1 W=8 TAP1=5 TAP2=18 DUT.
module tb_descramble_mw;
  localparam int WA = 10, T1A = 4, T2A = 23;
  localparam int WB = 8,  T1B = 5, T2B = 18;

  logic rclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 rclk = ~rclk;

  logic a_valid = 1'b0, a_flush = 1'b0, a_bypass = 1'b0;
  logic [WA-1:0] a_data = '0;
  logic a_ovalid, a_locked;
  logic [WA-1:0] a_odata;

  logic b_valid = 1'b0, b_flush = 1'b0, b_bypass = 1'b0;
  logic [WB-1:0] b_data = '0;
  logic b_ovalid, b_locked;
  logic [WB-1:0] b_odata;
`ifdef DESCRAMBLE_MW_WORDCNT_EN
  logic [31:0] a_wcnt, b_wcnt;
`endif

  descramble_mw dut_a (
    .rclk(rclk), .rst_n(rst_n), .in_valid(a_valid), .in_data(a_data),
    .flush(a_flush), .bypass(a_bypass), .out_valid(a_ovalid),
    .out_data(a_odata), .locked(a_locked)
`ifdef DESCRAMBLE_MW_WORDCNT_EN
    , .word_cnt(a_wcnt)
`endif
  );

  descramble_mw #(.W(WB), .TAP1(T1B), .TAP2(T2B), .DROP_UNLOCKED(1'b1)) dut_b (
    .rclk(rclk), .rst_n(rst_n), .in_valid(b_valid), .in_data(b_data),
    .flush(b_flush), .bypass(b_bypass), .out_valid(b_ovalid),
    .out_data(b_odata), .locked(b_locked)
`ifdef DESCRAMBLE_MW_WORDCNT_EN
    , .word_cnt(b_wcnt)
`endif
  );

  int n_chk = 0, n_pass = 0;

  // Model: line bit streams, oldest first, with the seed prepended (seed bit 0 is newest)
  bit qa[$], qb[$], sa[$];
  int na, nb;                       // accepts since reset/flush
  logic [WA-1:0] ea_data;
  logic [WB-1:0] eb_data;
  bit ea_valid, ea_locked, eb_valid, eb_locked;

  task automatic model_reset_a();
    logic [T2A-1:0] sd;
    sd = T2A'(1);
    qa.delete();
    for (int k = T2A - 1; k >= 0; k--) qa.push_back(sd[k]);
    na = 0; ea_valid = 0; ea_locked = 0;
  endtask

  task automatic model_reset_b();
    logic [T2B-1:0] sd;
    sd = T2B'(1);
    qb.delete();
    for (int k = T2B - 1; k >= 0; k--) qb.push_back(sd[k]);
    nb = 0; eb_valid = 0; eb_locked = 0;
  endtask

  // serial descrambler: d[n] = s[n] ^ s[n-TAP1] ^ s[n-TAP2]
  task automatic model_a(input bit v, input logic [WA-1:0] din, input bit fl, input bit byp);
    logic [WA-1:0] dw;
    if (fl) begin model_reset_a(); return; end
    if (!v) begin ea_valid = 0; return; end
    for (int k = WA - 1; k >= 0; k--) begin
      qa.push_back(din[k]);
      dw[k] = qa[qa.size()-1] ^ qa[qa.size()-1-T1A] ^ qa[qa.size()-1-T2A];
    end
    while (qa.size() > 64) void'(qa.pop_front());
    ea_data = byp ? din : dw;
    na++;
    ea_valid = 1;
    ea_locked = (na >= 3);
  endtask

  task automatic model_b(input logic [WB-1:0] din);
    logic [WB-1:0] dw;
    for (int k = WB - 1; k >= 0; k--) begin
      qb.push_back(din[k]);
      dw[k] = qb[qb.size()-1] ^ qb[qb.size()-1-T1B] ^ qb[qb.size()-1-T2B];
    end
    while (qb.size() > 64) void'(qb.pop_front());
    eb_data = dw;
    nb++;
    eb_locked = (nb >= 3);
    eb_valid = eb_locked;       // unlocked words are dropped
  endtask

  // serial scrambler: s[n] = d[n] ^ s[n-TAP1] ^ s[n-TAP2]
  function automatic logic [WA-1:0] scramble(input logic [WA-1:0] din);
    logic [WA-1:0] s;
    bit b;
    for (int k = WA - 1; k >= 0; k--) begin
      b = din[k] ^ sa[sa.size()-T1A] ^ sa[sa.size()-T2A];
      sa.push_back(b);
      s[k] = b;
    end
    while (sa.size() > 64) void'(sa.pop_front());
    return s;
  endfunction

  task automatic step_a(input bit v, input logic [WA-1:0] din, input bit fl, input bit byp);
    a_valid = v; a_data = din; a_flush = fl; a_bypass = byp;
    model_a(v, din, fl, byp);
    @(posedge rclk); #1;
    a_valid = 0; a_flush = 0; a_bypass = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    a_valid = 1; a_data = WA'($urandom);
    b_valid = 1; b_data = WB'($urandom);
    @(posedge rclk); #1;
    n_chk++; if (a_ovalid !== 1'b0) $display("FAIL reset a_valid: got %b want 0", a_ovalid); else n_pass++;
    n_chk++; if (a_odata !== '0) $display("FAIL reset a_data: got %h want 0", a_odata); else n_pass++;
    n_chk++; if (a_locked !== 1'b0) $display("FAIL reset a_locked: got %b want 0", a_locked); else n_pass++;
    n_chk++; if (b_ovalid !== 1'b0 || b_locked !== 1'b0) $display("FAIL reset b: got v=%b l=%b want 0 0", b_ovalid, b_locked); else n_pass++;
`ifdef DESCRAMBLE_MW_WORDCNT_EN
    n_chk++; if (a_wcnt !== 32'd0) $display("FAIL reset word_cnt: got %0d want 0", a_wcnt); else n_pass++;
`endif
    a_valid = 0; b_valid = 0;
    rst_n = 1;
    model_reset_a(); model_reset_b();
    ea_data = '0; eb_data = '0;
    sa.delete();
    for (int k = 0; k < T2A; k++) sa.push_back(1'($urandom));
  endtask

  task automatic test_lock(input int n, input string tag);
    logic [WA-1:0] x;
    for (int i = 0; i < n; i++) begin
      x = WA'($urandom);
      step_a(1'b1, scramble(x), 1'b0, 1'b0);
      n_chk++; if (a_ovalid !== 1'b1) $display("FAIL %s valid: got %b want 1", tag, a_ovalid); else n_pass++;
      n_chk++; if (a_locked !== ea_locked) $display("FAIL %s locked acc%0d: got %b want %b", tag, na, a_locked, ea_locked); else n_pass++;
      n_chk++; if (a_odata !== ea_data) $display("FAIL %s data acc%0d: got %h want %h", tag, na, a_odata, ea_data); else n_pass++;
      if (na >= 4) begin
        n_chk++; if (a_odata !== x) $display("FAIL %s recover acc%0d: got %h want %h", tag, na, a_odata, x); else n_pass++;
      end
    end
  endtask

  task automatic test_bypass();
    logic [WA-1:0] x, s;
    x = WA'($urandom); s = scramble(x);
    step_a(1'b1, s, 1'b0, 1'b1);
    n_chk++; if (a_ovalid !== 1'b1) $display("FAIL bypass valid: got %b want 1", a_ovalid); else n_pass++;
    n_chk++; if (a_odata !== s) $display("FAIL bypass raw: got %h want %h", a_odata, s); else n_pass++;
    x = WA'($urandom);
    step_a(1'b1, scramble(x), 1'b0, 1'b0);
    n_chk++; if (a_odata !== x) $display("FAIL bypass next word: got %h want %h", a_odata, x); else n_pass++;
  endtask

  task automatic test_flush();
    logic [WA-1:0] x;
    step_a(1'b1, scramble(WA'($urandom)), 1'b1, 1'b0);
    n_chk++; if (a_ovalid !== 1'b0) $display("FAIL flush valid: got %b want 0", a_ovalid); else n_pass++;
    n_chk++; if (a_locked !== 1'b0) $display("FAIL flush locked: got %b want 0", a_locked); else n_pass++;
    n_chk++; if (a_odata !== ea_data) $display("FAIL flush hold: got %h want %h", a_odata, ea_data); else n_pass++;
    for (int i = 1; i <= 3; i++) begin
      x = WA'($urandom);
      step_a(1'b1, scramble(x), 1'b0, 1'b0);
      n_chk++; if (a_locked !== (i == 3)) $display("FAIL flush relock w%0d: got %b want %b", i, a_locked, (i == 3)); else n_pass++;
      n_chk++; if (a_odata !== ea_data) $display("FAIL flush data w%0d: got %h want %h", i, a_odata, ea_data); else n_pass++;
    end
  endtask

  task automatic test_gaps();
    bit pat [6] = '{1, 0, 0, 1, 1, 0};
    step_a(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step_a(pat[i], pat[i] ? scramble(WA'($urandom)) : WA'($urandom), 1'b0, 1'b0);
      n_chk++; if (a_ovalid !== pat[i]) $display("FAIL gaps valid c%0d: got %b want %b", i, a_ovalid, pat[i]); else n_pass++;
      n_chk++; if (a_odata !== ea_data) $display("FAIL gaps data c%0d: got %h want %h", i, a_odata, ea_data); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    a_valid = 1; a_data = WA'($urandom);
    #2 rst_n = 0;
    #1;
    n_chk++; if (a_ovalid !== 1'b0 || a_locked !== 1'b0 || a_odata !== '0)
      $display("FAIL midreset async: got v=%b l=%b d=%h want 0 0 0", a_ovalid, a_locked, a_odata); else n_pass++;
    @(posedge rclk); #1;
    n_chk++; if (a_ovalid !== 1'b0) $display("FAIL midreset no word: got %b want 0", a_ovalid); else n_pass++;
    a_valid = 0;
    rst_n = 1;
    model_reset_a(); model_reset_b();
    ea_data = '0; eb_data = '0;
  endtask

  task automatic test_drop();
    logic [WB-1:0] x;
    for (int i = 1; i <= 8; i++) begin
      x = WB'($urandom);
      b_valid = 1; b_data = x; model_b(x);
      @(posedge rclk); #1;
      b_valid = 0;
      n_chk++; if (b_ovalid !== eb_valid) $display("FAIL drop valid w%0d: got %b want %b", i, b_ovalid, eb_valid); else n_pass++;
      n_chk++; if (b_locked !== eb_locked) $display("FAIL drop locked w%0d: got %b want %b", i, b_locked, eb_locked); else n_pass++;
      if (eb_valid) begin
        n_chk++; if (b_odata !== eb_data) $display("FAIL drop data w%0d: got %h want %h", i, b_odata, eb_data); else n_pass++;
      end
    end
  endtask

`ifdef DESCRAMBLE_MW_WORDCNT_EN
  task automatic test_wordcnt();
    test_lock(100, "wcnt");
    n_chk++; if (a_wcnt !== 32'd98) $display("FAIL wcnt 100 words: got %0d want 98", a_wcnt); else n_pass++;
    step_a(1'b0, '0, 1'b1, 1'b0);
    n_chk++; if (a_wcnt !== 32'd0) $display("FAIL wcnt flush: got %0d want 0", a_wcnt); else n_pass++;
    test_lock(3, "wcnt_relock");
    n_chk++; if (a_wcnt !== 32'd1) $display("FAIL wcnt relock: got %0d want 1", a_wcnt); else n_pass++;
    force dut_a.word_cnt = 32'hFFFF_FFFE;
    #1 release dut_a.word_cnt;
    test_lock(3, "wcnt_sat");
    n_chk++; if (a_wcnt !== 32'hFFFF_FFFF) $display("FAIL wcnt saturate: got %h want ffffffff", a_wcnt); else n_pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lock(9, "lock");           // words 1..9
    test_bypass();                  // words 10, 11
    test_lock(38, "stream");        // words 12..49
    test_flush();                   // word 50 flushed, 3 relock words
    test_lock(147, "stream2");
    test_gaps();
    test_reset_mid();
    test_drop();
`ifdef DESCRAMBLE_MW_WORDCNT_EN
    test_wordcnt();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
